// File: rtl/sdram_wr_port.sv
// ============================================================================
//  Module   : sdram_wr_port
//  Purpose  : SDRAM write front end. Buffers a 16-bit stream in a show-ahead
//             FIFO and issues one write burst per BURST_LEN buffered words.
//  Option   : SDRAM_WR_PORT_DROP_CNT_EN builds the dropped-word counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_wr_port #(
    parameter int BURST_LEN = 256,
    parameter int FIFO_AW   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [15:0]        wr_data,
    input  logic [20:0]        addr_min,
    input  logic [20:0]        addr_max,
    input  logic               sdram_init_done,
    input  logic               sdram_wr_ack,
    output logic               sdram_wr_req,
    output logic [20:0]        sdram_wr_addr,
    output logic [9:0]         sdram_wr_burst,
    output logic [15:0]        sdram_din,
    output logic               wr_full,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic [15:0]        drop_cnt
);

    localparam int                 c_DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_DEPTH_LVL = (FIFO_AW+1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]   c_BURST_LVL = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [10:0]        c_BURST_CNT = 11'(BURST_LEN);
    localparam logic [21:0]        c_BURST_ADR = 22'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2,
        S_NEXT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [20:0]          addr_q, addr_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic                 pend_q, pend_d;
    logic [10:0]          pop_cnt_q, pop_cnt_d;
    logic [15:0]          mem [c_DEPTH];

    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_clear;
    logic [21:0]          w_sum;
    logic [FIFO_AW-1:0]   w_waddr;

    assign w_push  = wr_en && !full_q;
    assign w_drop  = wr_en && full_q;
    assign w_pop   = sdram_wr_ack && (pop_cnt_q < c_BURST_CNT) &&
                     ((state_q == S_REQ) || (state_q == S_BURST));
    // A restart takes effect only between bursts; mid-burst it waits for NEXT.
    assign w_clear = (frame_start && ((state_q == S_IDLE) || (state_q == S_NEXT))) ||
                     ((state_q == S_NEXT) && pend_q);
    assign w_sum   = {1'b0, addr_q} + c_BURST_ADR;
    assign w_waddr = w_clear ? '0 : wr_ptr_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q | w_drop;
        pop_cnt_d = w_pop ? pop_cnt_q + 11'd1 : pop_cnt_q;
        rd_ptr_d  = w_pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        wr_ptr_d  = w_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        level_d   = level_q + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);

        case (state_q)
            S_IDLE: begin
                if (sdram_init_done && (level_q >= c_BURST_LVL) && !frame_start) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (frame_start) pend_d = 1'b1;
                if (sdram_wr_ack) begin
                    state_d = S_BURST;
                    req_d   = 1'b0;
                end
            end
            S_BURST: begin
                if (frame_start) pend_d = 1'b1;
                if (!sdram_wr_ack) state_d = S_NEXT;
            end
            default: begin
                addr_d    = (w_sum > {1'b0, addr_max}) ? addr_min : w_sum[20:0];
                pop_cnt_d = '0;
                pend_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // A word pushed alongside the clear becomes word 0 of the new frame.
        if (w_clear) begin
            addr_d   = addr_min;
            rd_ptr_d = '0;
            wr_ptr_d = w_push ? FIFO_AW'(1) : '0;
            level_d  = w_push ? (FIFO_AW+1)'(1) : '0;
        end

        full_d = (level_d == c_DEPTH_LVL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= addr_min;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem[w_waddr] <= wr_data;
    end

`ifdef SDRAM_WR_PORT_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            drop_cnt_q <= '0;
        end else if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign sdram_wr_req   = req_q;
    assign sdram_wr_addr  = addr_q;
    assign sdram_wr_burst = 10'(BURST_LEN);
    assign sdram_din      = mem[rd_ptr_q];
    assign wr_full        = full_q;
    assign fifo_level     = level_q;
    assign overflow       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_wr_port.sv
// ============================================================================
//  Module   : tb_sdram_wr_port
//  Purpose  : Self-checking bench for sdram_wr_port against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_wr_port;

    localparam int BL    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = '0;
    logic [20:0]   addr_min = '0;
    logic [20:0]   addr_max = 21'h1FFFFF;
    logic          init_done = 1'b0;
    logic          ack = 1'b0;
    logic          sdram_wr_req;
    logic [20:0]   sdram_wr_addr;
    logic [9:0]    sdram_wr_burst;
    logic [15:0]   sdram_din;
    logic          wr_full;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int            n_vec = 0;
    int            n_err = 0;

    logic [15:0]   q[$];
    logic [20:0]   m_addr;
    int            m_drop;
    bit            m_ovf;

    sdram_wr_port #(
        .BURST_LEN (BL),
        .FIFO_AW   (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .addr_min        (addr_min),
        .addr_max        (addr_max),
        .sdram_init_done (init_done),
        .sdram_wr_ack    (ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_din       (sdram_din),
        .wr_full         (wr_full),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_drop();
`ifdef SDRAM_WR_PORT_DROP_CNT_EN
        return 16'(m_drop);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic do_reset(input logic [20:0] amin, input logic [20:0] amax);
        addr_min    = amin;
        addr_max    = amax;
        rst_n       = 1'b0;
        ack         = 1'b0;
        wr_en       = 1'b0;
        frame_start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        q.delete();
        m_addr = amin;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (q.size() < DEPTH) begin
            q.push_back(d);
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
    endtask

    // Waits for a request, plays the controller for n_ack ack cycles and
    // optionally pulses frame_start on ack cycle fs_at.
    task automatic run_burst(input int n_ack, input int fs_at, input string tag);
        int t;
        int popped;
        int a;
        bit pend;
        t = 0;
        while (sdram_wr_req !== 1'b1 && t < 40) begin
            step();
            t++;
        end
        n_vec++;
        if (sdram_wr_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s req_timeout got %b want 1", tag, sdram_wr_req);
            return;
        end
        n_vec++;
        if (sdram_wr_addr !== m_addr) begin
            n_err++;
            $display("FAIL %s req_addr got %h want %h", tag, sdram_wr_addr, m_addr);
        end
        popped = 0;
        pend   = 1'b0;
        for (int i = 0; i < n_ack; i++) begin
            ack         = 1'b1;
            frame_start = (i == fs_at);
            if (popped < BL) begin
                n_vec++;
                if (sdram_din !== q[0]) begin
                    n_err++;
                    $display("FAIL %s din[%0d] got %h want %h", tag, i, sdram_din, q[0]);
                end
            end
            step();
            if (frame_start) begin
                pend   = 1'b1;
                m_drop = 0;
            end
            frame_start = 1'b0;
            if (popped < BL) begin
                void'(q.pop_front());
                popped++;
            end
            if (i == 0) begin
                n_vec++;
                if (sdram_wr_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s req_fall got %b want 0", tag, sdram_wr_req);
                end
            end
        end
        ack = 1'b0;
        step();
        n_vec++;
        if (sdram_wr_addr !== m_addr) begin
            n_err++;
            $display("FAIL %s addr_stable got %h want %h", tag, sdram_wr_addr, m_addr);
        end
        step();
        if (pend) begin
            q.delete();
            m_addr = addr_min;
        end else begin
            a = int'(m_addr) + BL;
            m_addr = (a > int'(addr_max)) ? addr_min : 21'(a);
        end
        n_vec++;
        if (sdram_wr_addr !== m_addr) begin
            n_err++;
            $display("FAIL %s next_addr got %h want %h", tag, sdram_wr_addr, m_addr);
        end
        n_vec++;
        if (fifo_level !== (AW+1)'(q.size())) begin
            n_err++;
            $display("FAIL %s level got %0d want %0d", tag, fifo_level, q.size());
        end
        n_vec++;
        if (sdram_wr_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s spacing_req got %b want 0", tag, sdram_wr_req);
        end
    endtask

    task automatic test_reset();
        do_reset(21'h100, 21'h1FFFFF);
        n_vec++;
        if (sdram_wr_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", sdram_wr_req); end
        n_vec++;
        if (sdram_wr_addr !== 21'h100) begin n_err++; $display("FAIL reset_addr got %h want 100", sdram_wr_addr); end
        n_vec++;
        if (fifo_level !== '0 || wr_full !== 1'b0) begin
            n_err++; $display("FAIL reset_fifo got level %0d full %b want 0 0", fifo_level, wr_full);
        end
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 16'h0) begin
            n_err++; $display("FAIL reset_ovf got %b/%h want 0/0", overflow, drop_cnt);
        end
        n_vec++;
        if (sdram_wr_burst !== 10'd4) begin n_err++; $display("FAIL burst_len got %0d want 4", sdram_wr_burst); end
    endtask

    task automatic test_single_burst();
        do_reset(21'h100, 21'h1FFFFF);
        init_done = 1'b1;
        for (int i = 1; i <= 4; i++) push(16'(i));
        n_vec++;
        if (fifo_level !== 4'd4 || sdram_wr_req !== 1'b0) begin
            n_err++; $display("FAIL single_pre got level %0d req %b want 4 0", fifo_level, sdram_wr_req);
        end
        step();
        n_vec++;
        if (sdram_wr_req !== 1'b1) begin n_err++; $display("FAIL single_latency got %b want 1", sdram_wr_req); end
        run_burst(4, -1, "single");
        n_vec++;
        if (sdram_wr_addr !== 21'h104) begin n_err++; $display("FAIL single_addr got %h want 104", sdram_wr_addr); end
    endtask

    task automatic test_wrap();
        logic [20:0] exp_a [4];
        exp_a = '{21'h000, 21'h004, 21'h008, 21'h000};
        do_reset(21'h000, 21'h00B);
        init_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) push(16'($urandom));
            n_vec++;
            if (sdram_wr_addr !== exp_a[k]) begin
                n_err++; $display("FAIL wrap_addr%0d got %h want %h", k, sdram_wr_addr, exp_a[k]);
            end
            run_burst(4, -1, "wrap");
        end
    endtask

    task automatic test_overflow();
        do_reset(21'h100, 21'h1FFFFF);
        init_done = 1'b0;
        for (int i = 0; i < 10; i++) push(16'($urandom));
        n_vec++;
        if (wr_full !== 1'b1 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_flags got full %b ovf %b want 1 1", wr_full, overflow);
        end
        n_vec++;
        if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
        n_vec++;
        if (drop_cnt !== exp_drop()) begin n_err++; $display("FAIL ovf_drop got %0d want %0d", drop_cnt, exp_drop()); end
    endtask

    task automatic test_init_gating();
        do_reset(21'h200, 21'h1FFFFF);
        init_done = 1'b0;
        for (int i = 0; i < 8; i++) push(16'($urandom));
        repeat (3) step();
        n_vec++;
        if (sdram_wr_req !== 1'b0) begin n_err++; $display("FAIL gate_noreq got %b want 0", sdram_wr_req); end
        init_done = 1'b1;
        step();
        n_vec++;
        if (sdram_wr_req !== 1'b1) begin n_err++; $display("FAIL gate_req got %b want 1", sdram_wr_req); end
        run_burst(4, -1, "gate_a");
        run_burst(4, -1, "gate_b");
    endtask

    task automatic test_frame_restart();
        do_reset(21'h100, 21'h1FFFFF);
        init_done = 1'b1;
        for (int i = 0; i < 4; i++) push(16'($urandom));
        run_burst(4, -1, "fs_pre");
        for (int i = 0; i < 6; i++) push(16'($urandom));
        run_burst(4, 1, "fs_mid");
        n_vec++;
        if (sdram_wr_addr !== 21'h100 || fifo_level !== 4'd0) begin
            n_err++; $display("FAIL fs_after got addr %h level %0d want 100 0", sdram_wr_addr, fifo_level);
        end
        // Restart while idle, with a word pushed in the same cycle.
        for (int i = 0; i < 2; i++) push(16'($urandom));
        wr_en       = 1'b1;
        wr_data     = 16'hABCD;
        frame_start = 1'b1;
        step();
        wr_en       = 1'b0;
        frame_start = 1'b0;
        q.delete();
        q.push_back(16'hABCD);
        m_addr = addr_min;
        m_drop = 0;
        n_vec++;
        if (fifo_level !== 4'd1) begin n_err++; $display("FAIL fs_idle_level got %0d want 1", fifo_level); end
        for (int i = 0; i < 3; i++) push(16'($urandom));
        run_burst(4, -1, "fs_idle");
    endtask

    task automatic test_random();
        int n;
        int nack;
        int fs;
        do_reset(21'h040, 21'h05D);
        init_done = 1'b1;
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) push(16'($urandom));
            n_vec++;
            if (fifo_level !== (AW+1)'(q.size()) || wr_full !== (q.size() == DEPTH)) begin
                n_err++;
                $display("FAIL rnd_level got %0d/%b want %0d", fifo_level, wr_full, q.size());
            end
            n_vec++;
            if (overflow !== m_ovf || drop_cnt !== exp_drop()) begin
                n_err++;
                $display("FAIL rnd_ovf got %b/%0d want %b/%0d", overflow, drop_cnt, m_ovf, exp_drop());
            end
            if (q.size() >= BL) begin
                nack = $urandom_range(1, 6);
                fs   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nack - 1)) : -1;
                run_burst(nack, fs, "rnd");
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        do_reset(21'h300, 21'h1FFFFF);
        init_done = 1'b0;
        for (int i = 0; i < 10; i++) push(16'($urandom));
        init_done = 1'b1;
        t = 0;
        while (sdram_wr_req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        n_vec++;
        if (sdram_wr_req !== 1'b1) begin n_err++; $display("FAIL rstb_req got %b want 1", sdram_wr_req); end
        ack = 1'b1;
        step();
        step();
        ack   = 1'b0;
        rst_n = 1'b0;
        step();
        n_vec++;
        if (sdram_wr_req !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || wr_full !== 1'b0) begin
            n_err++;
            $display("FAIL rstb_state got req %b level %0d ovf %b full %b want 0 0 0 0",
                     sdram_wr_req, fifo_level, overflow, wr_full);
        end
        n_vec++;
        if (drop_cnt !== 16'h0 || sdram_wr_addr !== 21'h300) begin
            n_err++; $display("FAIL rstb_regs got drop %0d addr %h want 0 300", drop_cnt, sdram_wr_addr);
        end
        rst_n = 1'b1;
        repeat (3) step();
        n_vec++;
        if (sdram_wr_req !== 1'b0) begin n_err++; $display("FAIL rstb_idle got %b want 0", sdram_wr_req); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_overflow();
        test_init_gating();
        test_frame_restart();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
